// File: rtl/snn_pkg.sv
// Shared types for the spiking-network datapath.
//   SPIKE_W      : default width of a signed spike/weight value
//   spike_val_t  : signed value of SPIKE_W bits
//   syn_state_t  : synapse accumulator step FSM (IDLE / SCAN / EMIT)
package snn_pkg;

  localparam int SPIKE_W = 16;

  typedef logic signed [SPIKE_W-1:0] spike_val_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } syn_state_t;

endpackage

// File: rtl/synapse_weight_regfile.sv
// Synapse weight storage: N_INPUTS x W_WIDTH, cleared by reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   we         : write enable (accepted every cycle)
//   waddr      : write index
//   wdata      : write value
//   raddr      : asynchronous read index (scan index)
//   rdata      : weight at raddr
// A write lands on the clock edge, so a same-cycle read of that entry
// still returns the old value.
module synapse_weight_regfile #(
  parameter int N_INPUTS = 8,
  parameter int W_WIDTH  = 16,
  localparam int AW      = $clog2(N_INPUTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [W_WIDTH-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [W_WIDTH-1:0] rdata
);

  logic [N_INPUTS-1:0][W_WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/synapse_accumulator.sv
// Weighted-synapse stage: per time step, snapshot the pre-synaptic spikes
// and sum the signed weight of every active input, one input per cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : time-step strobe, honoured only in IDLE
//   pre_spike     : one spike bit per input neuron
//   weight_we/addr/data : weight register write port
//   spiking_value : signed step sum, held between steps
//   out_valid     : one-cycle pulse when spiking_value updates
//   window_done   : pulse on the last out_valid of a T_WINDOW window
//   busy          : high during SCAN and EMIT
// Build option SYN_SAT_EN: clamp the sum to the W_WIDTH signed range
// instead of keeping the low W_WIDTH bits.
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int W_WIDTH  = SPIKE_W,
  parameter int T_WINDOW = 250,
  localparam int IDX_W   = $clog2(N_INPUTS),
  localparam int ACC_W   = W_WIDTH + IDX_W,
  localparam int CNT_W   = (T_WINDOW > 1) ? $clog2(T_WINDOW) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [N_INPUTS-1:0]       pre_spike,
  input  logic                      weight_we,
  input  logic [IDX_W-1:0]          weight_addr,
  input  logic [W_WIDTH-1:0]        weight_data,
  output logic signed [W_WIDTH-1:0] spiking_value,
  output logic                      out_valid,
  output logic                      window_done,
  output logic                      busy
);

  syn_state_t state, state_nxt;

  logic [N_INPUTS-1:0]     snap;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]        step_cnt;
  logic [W_WIDTH-1:0]      w_rd;

  logic                    scan_last;
  logic                    cnt_last;

  // next-cycle values of the registered outputs
  logic                    ov_d, wd_d, busy_d;
  logic [W_WIDTH-1:0]      sv_d;

  synapse_weight_regfile #(
    .N_INPUTS (N_INPUTS),
    .W_WIDTH  (W_WIDTH)
  ) u_wrf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (weight_we),
    .waddr (weight_addr),
    .wdata (weight_data),
    .raddr (idx),
    .rdata (w_rd)
  );

  assign scan_last = (state == SCAN) && (idx == IDX_W'(N_INPUTS - 1));
  assign cnt_last  = (step_cnt == CNT_W'(T_WINDOW - 1));

  // Running sum including the input scanned this cycle; on the last SCAN
  // cycle this is the final step total, so the output register loads it on
  // the edge into EMIT and out_valid is visible during EMIT.
  assign acc_nxt = snap[idx] ? acc + {{IDX_W{w_rd[W_WIDTH-1]}}, w_rd} : acc;

`ifdef SYN_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(IDX_W+1){1'b0}}, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(IDX_W+1){1'b1}}, {(W_WIDTH-1){1'b0}}};

  function automatic logic [W_WIDTH-1:0] conv(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI)      conv = SAT_HI[W_WIDTH-1:0];
    else if (a < SAT_LO) conv = SAT_LO[W_WIDTH-1:0];
    else                 conv = a[W_WIDTH-1:0];
  endfunction
`else
  function automatic logic [W_WIDTH-1:0] conv(input logic signed [ACC_W-1:0] a);
    conv = a[W_WIDTH-1:0];
  endfunction
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = EMIT;
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (registered below) ----------------
  always_comb begin
    ov_d   = scan_last;
    wd_d   = scan_last && cnt_last;
    busy_d = (state_nxt != IDLE);
    sv_d   = scan_last ? conv(acc_nxt) : spiking_value;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap          <= '0;
      idx           <= '0;
      acc           <= '0;
      step_cnt      <= '0;
      spiking_value <= '0;
      out_valid     <= 1'b0;
      window_done   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      out_valid     <= ov_d;
      window_done   <= wd_d;
      busy          <= busy_d;
      spiking_value <= sv_d;
      if (state == IDLE && en) begin
        snap <= pre_spike;
        acc  <= '0;
        idx  <= '0;
      end else if (state == SCAN) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
      end
      if (scan_last) step_cnt <= cnt_last ? '0 : step_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
module tb_synapse_accumulator;
  import snn_pkg::*;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int TW = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [N-1:0]     pre_spike;
  logic             weight_we;
  logic [2:0]       weight_addr;
  logic [W-1:0]     weight_data;
  spike_val_t       spiking_value;
  logic             out_valid;
  logic             window_done;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  synapse_accumulator #(
    .N_INPUTS (N),
    .W_WIDTH  (W),
    .T_WINDOW (TW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .pre_spike     (pre_spike),
    .weight_we     (weight_we),
    .weight_addr   (weight_addr),
    .weight_data   (weight_data),
    .spiking_value (spiking_value),
    .out_valid     (out_valid),
    .window_done   (window_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    weight_we   = 1'b1;
    weight_addr = 3'(a);
    weight_data = 16'(d);
    tick();
    weight_we   = 1'b0;
  endtask

  // bounded wait for out_valid; cyc counts edges waited
  task automatic wait_ov(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  // one full step from IDLE: checks latency, busy length, sum, window flag,
  // and that out_valid/busy fall after EMIT
  task automatic do_step(input string tag, input logic [N-1:0] pre,
                         input int exp_sv, input int exp_wd);
    int lat, bcnt;
    pre_spike = pre;
    en = 1'b1;
    tick();
    en = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!out_valid && lat < 30) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    if (busy) bcnt++;
    chk({tag, ".lat"}, lat, 9);
    chk({tag, ".sv"}, int'(spiking_value), exp_sv);
    chk({tag, ".wd"}, int'(window_done), exp_wd);
    tick();
    chk({tag, ".busy_cycles"}, bcnt, 9);
    chk({tag, ".ov_fall"}, int'({out_valid, busy}), 0);
  endtask

  initial begin
    int cyc, extra;
    rst_n = 1'b0; en = 1'b0; pre_spike = '0;
    weight_we = 1'b0; weight_addr = '0; weight_data = '0;
    tick(); tick();

    // reset state
    chk("rst.sv",   int'(spiking_value), 0);
    chk("rst.ov",   int'(out_valid), 0);
    chk("rst.wd",   int'(window_done), 0);
    chk("rst.busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // basic sum: 100 + (-40)
    wr(0, 100);
    wr(3, -40);
    do_step("basic", 8'b0000_1001, 60, 0);

    // large sum: 8 x 20000 = 160000
    for (int i = 0; i < N; i++) wr(i, 20000);
`ifdef SYN_SAT_EN
    do_step("sat", 8'hFF, 32767, 0);
`else
    do_step("wrap", 8'hFF, 28928, 0);
`endif

    // weights 1,2,4,...,128 -> sum equals the snapshot value
    for (int i = 0; i < N; i++) wr(i, 1 << i);
    pre_spike = 8'h05;
    en = 1'b1;
    tick();
    pre_spike = 8'hFF;
    tick(); tick(); tick();
    en = 1'b0;
    wait_ov(cyc);
    chk("snap.ov_seen", int'(out_valid), 1);
    chk("snap.sv", int'(spiking_value), 5);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) extra++;
    end
    chk("snap.extra_ov", extra, 0);

    // same-cycle write to the index being scanned: 4th step of the window
    wr(2, 50);
    pre_spike = 8'h04;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick(); tick();
    weight_we = 1'b1; weight_addr = 3'd2; weight_data = 16'd7;
    tick();
    weight_we = 1'b0;
    wait_ov(cyc);
    chk("hazard.ov_seen", int'(out_valid), 1);
    chk("hazard.sv", int'(spiking_value), 50);
    chk("hazard.wd", int'(window_done), 1);
    tick();
    do_step("hazard_next", 8'h04, 7, 0);

    // reset at the 3rd SCAN cycle
    pre_spike = 8'hFF;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick(); tick();
    chk("midrst.busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.sv",   int'(spiking_value), 0);
    chk("midrst.ov",   int'(out_valid), 0);
    chk("midrst.wd",   int'(window_done), 0);
    chk("midrst.busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) extra++;
    end
    chk("midrst.extra_ov", extra, 0);
    do_step("midrst_zero_w", 8'hFF, 0, 0);

    // window: fresh counter, five back-to-back steps
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr(0, 1);
    do_step("win1", 8'h01, 1, 0);
    do_step("win2", 8'h01, 1, 0);
    do_step("win3", 8'h01, 1, 0);
    do_step("win4", 8'h01, 1, 1);
    do_step("win5", 8'h01, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
